// File: rtl/bundle_fetch_unit_if.sv
// Fetch-unit bus bundle: IMMU request/ack channel, redirect, FU busy flags
// and the issue port toward the functional units.
//   master : the fetch unit (drives mem_req/mem_addr, issue_*, buf_count)
//   slave  : the environment (IMMU, branch unit, FUs)
interface bundle_fetch_unit_if #(
  parameter int NFU        = 2,
  parameter int INSTR_BITS = 32,
  parameter int DEPTH      = 4,
  parameter int ADDR_W     = 64
);
  localparam int BUNDLE_W = NFU * INSTR_BITS;
  localparam int CNT_W    = $clog2(DEPTH) + 1;

  logic                mem_req;
  logic [ADDR_W-1:0]   mem_addr;
  logic                mem_ack;
  logic [BUNDLE_W-1:0] mem_data;
  logic                redirect_valid;
  logic [ADDR_W-1:0]   redirect_pc;
  logic [NFU-1:0]      fu_busy;
  logic                issue_valid;
  logic [BUNDLE_W-1:0] issue_bundle;
  logic [ADDR_W-1:0]   issue_pc;
  logic [CNT_W-1:0]    buf_count;

  modport master (
    output mem_req, mem_addr, issue_valid, issue_bundle, issue_pc, buf_count,
    input  mem_ack, mem_data, redirect_valid, redirect_pc, fu_busy
  );

  modport slave (
    input  mem_req, mem_addr, issue_valid, issue_bundle, issue_pc, buf_count,
    output mem_ack, mem_data, redirect_valid, redirect_pc, fu_busy
  );
endinterface

// File: rtl/bundle_fetch_unit.sv
// VLIW bundle fetch/issue front end.
// Fetches NFU-slot bundles from the IMMU (one request in flight), buffers them
// in a DEPTH-entry FIFO and issues one bundle when every FU is idle.
// A redirect flushes the FIFO and discards any response still in flight.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   bus      : bundle_fetch_unit_if.master (mem_req/addr/ack/data,
//              redirect_valid/pc, fu_busy, issue_valid/bundle/pc, buf_count)
module bundle_fetch_unit #(
  parameter int                NFU        = 2,
  parameter int                INSTR_BITS = 32,
  parameter int                DEPTH      = 4,
  parameter int                ADDR_W     = 64,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0
) (
  input logic                 clk,
  input logic                 rst,
  bundle_fetch_unit_if.master bus
);
  localparam int BUNDLE_W     = NFU * INSTR_BITS;
  localparam int BUNDLE_BYTES = BUNDLE_W / 8;
  localparam int OFF_W        = $clog2(BUNDLE_BYTES);
  localparam int PTR_W        = $clog2(DEPTH);
  localparam int CNT_W        = PTR_W + 1;
  localparam logic [ADDR_W-1:0] STEP       = ADDR_W'(BUNDLE_BYTES);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~((ADDR_W'(1) << OFF_W) - ADDR_W'(1));
  localparam logic [CNT_W-1:0]  DEPTH_C    = CNT_W'(DEPTH);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_DISCARD} state_t;

  state_t              state_q, state_d;
  // fetch_pc holds the address of the next request to launch; it advances by
  // one bundle each time a request is raised.
  logic [ADDR_W-1:0]   fetch_pc_q, fetch_pc_d;
  logic                mem_req_q, mem_req_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [BUNDLE_W-1:0] fifo_bundle_q [DEPTH];
  logic [BUNDLE_W-1:0] fifo_bundle_d [DEPTH];
  logic [ADDR_W-1:0]   fifo_pc_q [DEPTH];
  logic [ADDR_W-1:0]   fifo_pc_d [DEPTH];
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                issue_valid_q, issue_valid_d;
  logic [BUNDLE_W-1:0] issue_bundle_q, issue_bundle_d;
  logic [ADDR_W-1:0]   issue_pc_q, issue_pc_d;

  logic              ack_done, push, pop, launch_ok;
  logic [ADDR_W-1:0] base_pc;

  always_comb begin
    ack_done = mem_req_q & bus.mem_ack;
    // Data from a discarded request, or acked alongside a redirect, is dropped.
    push     = (state_q == S_WAIT) & ack_done & ~bus.redirect_valid;
    // The issue_valid term forces a gap so the FUs can raise busy.
    pop      = (count_q != '0) & ~|bus.fu_busy & ~issue_valid_q & ~bus.redirect_valid;

    state_d        = state_q;
    mem_req_d      = mem_req_q;
    mem_addr_d     = mem_addr_q;
    fifo_bundle_d  = fifo_bundle_q;
    fifo_pc_d      = fifo_pc_q;
    rd_ptr_d       = rd_ptr_q;
    wr_ptr_d       = wr_ptr_q;
    count_d        = count_q;
    issue_valid_d  = 1'b0;
    issue_bundle_d = issue_bundle_q;
    issue_pc_d     = issue_pc_q;

    if (pop) begin
      issue_valid_d  = 1'b1;
      issue_bundle_d = fifo_bundle_q[rd_ptr_q];
      issue_pc_d     = fifo_pc_q[rd_ptr_q];
      rd_ptr_d       = rd_ptr_q + PTR_W'(1);
    end
    if (push) begin
      fifo_bundle_d[wr_ptr_q] = bus.mem_data;
      fifo_pc_d[wr_ptr_q]     = mem_addr_q;
      wr_ptr_d                = wr_ptr_q + PTR_W'(1);
    end

    if (bus.redirect_valid) begin
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else begin
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end

    base_pc    = bus.redirect_valid ? (bus.redirect_pc & ALIGN_MASK) : fetch_pc_q;
    fetch_pc_d = base_pc;

    case (state_q)
      S_WAIT:    if (!ack_done && bus.redirect_valid) state_d = S_DISCARD;
      S_DISCARD: if (ack_done) begin
                   state_d   = S_REQ;
                   mem_req_d = 1'b0;
                 end
      default:   state_d = state_q;
    endcase

    // A new request may go out from idle, or back-to-back on a normal ack.
    // Checking post-update occupancy keeps FIFO + in-flight <= DEPTH.
    launch_ok = (state_q == S_REQ) | ((state_q == S_WAIT) & ack_done);
    if (launch_ok) begin
      if (count_d < DEPTH_C) begin
        mem_req_d  = 1'b1;
        mem_addr_d = base_pc;
        fetch_pc_d = base_pc + STEP;
        state_d    = S_WAIT;
      end else begin
        mem_req_d = 1'b0;
        state_d   = S_REQ;
      end
    end
  end

  always_ff @(posedge clk) begin
    fifo_bundle_q <= fifo_bundle_d;
    fifo_pc_q     <= fifo_pc_d;
    if (rst) begin
      state_q        <= S_REQ;
      fetch_pc_q     <= RESET_PC;
      mem_req_q      <= 1'b0;
      mem_addr_q     <= RESET_PC;
      rd_ptr_q       <= '0;
      wr_ptr_q       <= '0;
      count_q        <= '0;
      issue_valid_q  <= 1'b0;
      issue_bundle_q <= '0;
      issue_pc_q     <= '0;
    end else begin
      state_q        <= state_d;
      fetch_pc_q     <= fetch_pc_d;
      mem_req_q      <= mem_req_d;
      mem_addr_q     <= mem_addr_d;
      rd_ptr_q       <= rd_ptr_d;
      wr_ptr_q       <= wr_ptr_d;
      count_q        <= count_d;
      issue_valid_q  <= issue_valid_d;
      issue_bundle_q <= issue_bundle_d;
      issue_pc_q     <= issue_pc_d;
    end
  end

  assign bus.mem_req      = mem_req_q;
  assign bus.mem_addr     = mem_addr_q;
  assign bus.issue_valid  = issue_valid_q;
  assign bus.issue_bundle = issue_bundle_q;
  assign bus.issue_pc     = issue_pc_q;
  assign bus.buf_count    = count_q;
endmodule

// File: tb/tb_bundle_fetch_unit.sv
// Bench for bundle_fetch_unit: directed scenarios, an IMMU responder with
// programmable latency, and a queue-based model checked every cycle.
module tb_bundle_fetch_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst2 = 1'b1;
  always #5 clk = ~clk;

  bundle_fetch_unit_if #(.NFU(2), .INSTR_BITS(32), .DEPTH(4), .ADDR_W(64)) bus ();
  bundle_fetch_unit_if #(.NFU(2), .INSTR_BITS(32), .DEPTH(4), .ADDR_W(64)) bus2 ();

  bundle_fetch_unit #(.NFU(2), .INSTR_BITS(32), .DEPTH(4), .ADDR_W(64),
                      .RESET_PC(64'h0)) dut (.clk(clk), .rst(rst), .bus(bus));
  bundle_fetch_unit #(.NFU(2), .INSTR_BITS(32), .DEPTH(4), .ADDR_W(64),
                      .RESET_PC(64'hFFFF_FFFF_FFFF_FFF8)) dut2 (.clk(clk), .rst(rst2), .bus(bus2));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [63:0] qat(input logic [63:0] q[$], input int i);
    return (i < q.size()) ? q[i] : 64'hDEAD_BEEF;
  endfunction

  // IMMU responder: acks after 'lat' wait cycles, or acks constantly.
  int lat = 0;
  bit ack_always = 1'b0;
  int wcnt = 0;
  bit r_done, r_rst;
  always @(posedge clk) begin
    r_done = bus.mem_req && bus.mem_ack;
    r_rst  = rst;
    #1;
    if (r_rst || r_done) wcnt = 0;
    if (ack_always) bus.mem_ack = 1'b1;
    else if (bus.mem_req) begin
      bus.mem_ack = (wcnt >= lat);
      wcnt++;
    end else bus.mem_ack = 1'b0;
    bus.mem_data = {~bus.mem_addr[31:0], bus.mem_addr[31:0] ^ 32'hA5A5_0000};
  end

  assign bus2.mem_ack        = 1'b1;
  assign bus2.mem_data       = 64'h0;
  assign bus2.redirect_valid = 1'b0;
  assign bus2.redirect_pc    = 64'h0;
  assign bus2.fu_busy        = 2'b11;

  // Model: a queue of {bundle, pc}; the pc expected for the next fetch; whether
  // the outstanding request has been made stale by a redirect.
  typedef struct { logic [63:0] b; logic [63:0] pc; } ent_t;
  ent_t mq[$];
  bit m_valid = 0, m_iv = 0, m_rst_just = 0, m_stale = 0;
  bit m_prev_req = 0, m_prev_ack = 0, m_done;
  logic [63:0] m_ib = 0, m_ipc = 0, m_exp = 0, m_prev_addr = 0;
  logic [63:0] launch_log[$], issue_log[$], log2[$];

  always @(negedge clk) begin
    if (m_valid) begin
      chk("buf_count", 64'(bus.buf_count), 64'(mq.size()));
      chk("issue_valid", 64'(bus.issue_valid), 64'(m_iv));
      chk("issue_bundle", bus.issue_bundle, m_ib);
      chk("issue_pc", bus.issue_pc, m_ipc);
      if (m_rst_just) begin
        chk("rst_mem_req", 64'(bus.mem_req), 64'h0);
        chk("rst_mem_addr", bus.mem_addr, 64'h0);
      end
      if (m_prev_req && !m_prev_ack) begin
        chk("hold_req", 64'(bus.mem_req), 64'h1);
        chk("hold_addr", bus.mem_addr, m_prev_addr);
      end else if (bus.mem_req) begin
        chk("launch_addr", bus.mem_addr, m_exp);
        launch_log.push_back(bus.mem_addr);
      end
      chk("no_overfill", 64'((mq.size() + int'(bus.mem_req && !m_stale)) <= 4), 64'h1);
      if (bus.issue_valid) issue_log.push_back(bus.issue_pc);
    end
    if (rst) begin
      mq.delete();
      m_iv = 0; m_ib = 0; m_ipc = 0; m_exp = 0; m_stale = 0;
      m_prev_req = 0; m_prev_ack = 0; m_rst_just = 1; m_valid = 1;
    end else begin
      m_done = bus.mem_req && bus.mem_ack;
      if (!bus.redirect_valid && mq.size() > 0 && bus.fu_busy == 0 && !m_iv) begin
        m_iv = 1; m_ib = mq[0].b; m_ipc = mq[0].pc;
        void'(mq.pop_front());
      end else m_iv = 0;
      if (bus.redirect_valid) begin
        mq.delete();
        m_exp   = bus.redirect_pc & ~64'h7;
        m_stale = bus.mem_req && !m_done;
      end else if (m_done) begin
        if (m_stale) m_stale = 0;
        else begin
          mq.push_back(ent_t'{bus.mem_data, bus.mem_addr});
          m_exp = m_exp + 64'h8;
        end
      end
      m_prev_req  = bus.mem_req;
      m_prev_ack  = m_done;
      m_prev_addr = bus.mem_addr;
      m_rst_just  = 0;
    end
  end

  // Launch log for the wrap-around instance.
  bit p2_req = 0, p2_ack = 0;
  always @(negedge clk) begin
    if (!rst2 && bus2.mem_req && (!p2_req || p2_ack)) log2.push_back(bus2.mem_addr);
    p2_req = rst2 ? 1'b0 : bus2.mem_req;
    p2_ack = bus2.mem_req && bus2.mem_ack;
  end

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    launch_log.delete();
    issue_log.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "timeout");
  end

  initial begin
    bit found;
    int hi, n;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 64'h0;
    bus.fu_busy        = 2'b00;

    // T1: constant ack (also while idle), FUs idle.
    ack_always = 1'b1;
    do_reset();
    repeat (12) tick();
    chk("t1_req0", qat(launch_log, 0), 64'h0);
    chk("t1_req1", qat(launch_log, 1), 64'h8);
    chk("t1_req2", qat(launch_log, 2), 64'h10);
    chk("t1_iss0", qat(issue_log, 0), 64'h0);
    chk("t1_iss1", qat(issue_log, 1), 64'h8);

    // T2: one FU busy -> FIFO fills to 4 and fetch stops.
    ack_always = 1'b0;
    lat = 0;
    bus.fu_busy = 2'b01;
    do_reset();
    repeat (20) tick();
    chk("t2_nreq", 64'(launch_log.size()), 64'd4);
    chk("t2_count", 64'(bus.buf_count), 64'd4);
    chk("t2_req_off", 64'(bus.mem_req), 64'h0);
    bus.fu_busy = 2'b00;
    repeat (12) tick();
    for (int i = 0; i < 4; i++) chk("t2_iss", qat(issue_log, i), 64'(i * 8));

    // T3: 3-cycle ack delay.
    lat = 3;
    bus.fu_busy = 2'b11;
    do_reset();
    hi = 0;
    for (int i = 0; i < 40 && bus.buf_count == 0; i++) begin
      if (bus.mem_req) hi++;
      tick();
    end
    chk("t3_req_cycles", 64'(hi), 64'd4);
    chk("t3_count1", 64'(bus.buf_count), 64'd1);
    repeat (10) tick();
    chk("t3_count3", 64'(bus.buf_count), 64'd3);

    // T4: redirect to 0x1004 while fetch of 0x10 waits for its ack.
    lat = 2;
    do_reset();
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (bus.mem_req && bus.mem_addr == 64'h10) found = 1; else tick();
    end
    chk("t4_found_0x10", 64'(found), 64'h1);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 64'h1004;
    tick();
    bus.redirect_valid = 1'b0;
    chk("t4_flush", 64'(bus.buf_count), 64'd0);
    chk("t4_discard_addr", bus.mem_addr, 64'h10);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (bus.mem_req && bus.mem_addr == 64'h1000) found = 1; else tick();
    end
    chk("t4_new_req", 64'(found), 64'h1);
    bus.fu_busy = 2'b00;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (bus.issue_valid) found = 1; else tick();
    end
    chk("t4_issue_seen", 64'(found), 64'h1);
    chk("t4_issue_pc", bus.issue_pc, 64'h1000);

    // T5: redirect coincides with an ack and an eligible issue.
    bus.fu_busy = 2'b11;
    do_reset();
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (bus.buf_count >= 1 && bus.mem_req && bus.mem_ack) found = 1; else tick();
    end
    chk("t5_found", 64'(found), 64'h1);
    bus.fu_busy        = 2'b00;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 64'h2000;
    tick();
    bus.redirect_valid = 1'b0;
    chk("t5_no_issue", 64'(bus.issue_valid), 64'h0);
    chk("t5_flush", 64'(bus.buf_count), 64'd0);
    chk("t5_req", 64'(bus.mem_req), 64'h1);
    chk("t5_addr", bus.mem_addr, 64'h2000);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (bus.issue_valid) found = 1; else tick();
    end
    chk("t5_issue_seen", 64'(found), 64'h1);
    chk("t5_issue_pc", bus.issue_pc, 64'h2000);

    // T6: reset in the middle of a long wait.
    lat = 5;
    bus.fu_busy = 2'b11;
    n = launch_log.size();
    for (int i = 0; i < 30 && launch_log.size() == n; i++) tick();
    chk("t6_launched", 64'(launch_log.size() > n), 64'h1);
    tick();
    rst = 1'b1;
    tick();
    chk("t6_req", 64'(bus.mem_req), 64'h0);
    chk("t6_addr", bus.mem_addr, 64'h0);
    chk("t6_iv", 64'(bus.issue_valid), 64'h0);
    chk("t6_ib", bus.issue_bundle, 64'h0);
    chk("t6_ipc", bus.issue_pc, 64'h0);
    chk("t6_cnt", 64'(bus.buf_count), 64'h0);
    rst = 1'b0;
    tick();

    // T7: address wrap from RESET_PC = 2^64-8.
    rst2 = 1'b0;
    repeat (6) tick();
    chk("t7_req0", qat(log2, 0), 64'hFFFF_FFFF_FFFF_FFF8);
    chk("t7_req1_wrap", qat(log2, 1), 64'h0);
    chk("t7_req2", qat(log2, 2), 64'h8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/bundle_fetch_unit.md
Name: bundle_fetch_unit

Overview:
- Parametrised bundle fetch and issue front end for the VLIW core.
- Fetches NFU-wide instruction bundles from the instruction MMU through a req/ack handshake, with one request outstanding at a time.
- Buffers fetched bundles in a DEPTH-entry prefetch FIFO and issues one bundle to all functional units when every FU is idle.
- Supports PC redirect (branch/exception) with buffer flush and discard of any in-flight response.

Parameters:
- NFU, 2: number of functional units (instruction slots per bundle).
- INSTR_BITS, 32: bits per slot instruction; must be a multiple of 8.
- DEPTH, 4: prefetch FIFO entries; power of two, at least 2.
- ADDR_W, 64: PC/address width.
- RESET_PC, 0: first fetch address after reset.
- Derived: BUNDLE_W = NFU*INSTR_BITS; BUNDLE_BYTES = BUNDLE_W/8.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- mem_req  out  1  fetch request to IMMU.
- mem_addr  out  ADDR_W  bundle address of current request.
- mem_ack  in  1  IMMU response valid; completes the request when sampled with mem_req=1.
- mem_data  in  BUNDLE_W  fetched bundle; valid when mem_ack=1.
- redirect_valid  in  1  one-cycle PC redirect.
- redirect_pc  in  ADDR_W  redirect target.
- fu_busy  in  NFU  per-FU working flags.
- issue_valid  out  1  one-cycle pulse: bundle presented to the FUs.
- issue_bundle  out  BUNDLE_W  bundle; slot k = bits [k*INSTR_BITS +: INSTR_BITS].
- issue_pc  out  ADDR_W  address of the issued bundle.
- buf_count  out  $clog2(DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset values: mem_req=0, mem_addr=RESET_PC, issue_valid=0, issue_bundle=0, issue_pc=0, buf_count=0. FSM enters REQ; fetch_pc=RESET_PC.
- Reset mid-transaction: the outstanding request is abandoned. The IMMU must also be reset by the same rst.
- FSM states:
  - REQ: mem_req=1 when buf_count + (pending enqueue) < DEPTH; otherwise mem_req=0.
  - WAIT: mem_req=1, mem_addr held stable until ack.
  - DISCARD: mem_req=1 at the old address until ack; the data is dropped.
- Handshake rules:
  - mem_req, once raised, is never dropped or changed before mem_ack.
  - Completion = mem_req & mem_ack on the same edge.
  - mem_ack while mem_req=0 is ignored.
- Normal completion:
  - mem_data and mem_addr are pushed into the FIFO.
  - fetch_pc increments by BUNDLE_BYTES, wrapping modulo 2^ADDR_W.
  - If space remains, the next request is raised on the following cycle. Minimum spacing: one idle cycle per fetch is permitted; back-to-back requests are preferred.
- Full: no new request is launched while the FIFO plus the in-flight request would exceed DEPTH. An ack can therefore never overflow the FIFO.
- Issue condition (registered, 1-cycle latency): FIFO non-empty, fu_busy == 0, issue_valid currently 0, and no redirect this cycle.
  - The pop drives issue_valid=1 next cycle with issue_bundle and issue_pc from the FIFO head.
  - issue_valid is held 1 for exactly one cycle. The forced gap gives the FUs one cycle to raise busy.
- Simultaneous push and pop: buf_count is unchanged; data ordering is preserved. An issue is allowed from a non-empty FIFO in the same cycle as a push; there is no bypass of an empty FIFO.
- Redirect:
  - FIFO flushed (buf_count=0 next cycle); no issue that cycle.
  - fetch_pc = redirect_pc with the low log2(BUNDLE_BYTES) bits cleared.
  - If a request is outstanding and not acked this cycle, go to DISCARD; after the ack, go to REQ with the new PC.
  - If the ack coincides with the redirect, the data is dropped and the next cycle requests redirect_pc.
  - A redirect arriving while in DISCARD only updates fetch_pc.
- issue_bundle and issue_pc hold their last value when issue_valid=0.

Test Plan:
- Reset, then mem_ack=1 every cycle after req, fu_busy=0 -> requests at 0x0, 0x8, 0x10, ...; issue_valid pulses every other cycle with issue_pc 0x0, 0x8 in order.
- fu_busy=2'b01 held for 20 cycles, IMMU always acks -> exactly 4 requests; buf_count saturates at 4 and mem_req stays 0; after release, 4 issues at 0x0–0x18.
- mem_ack delayed 3 cycles -> mem_req and mem_addr stable across the wait; a single enqueue per ack.
- Redirect to 0x1004 while a request to 0x10 is outstanding, ack 2 cycles later -> buf_count=0, ack data not issued, next mem_addr=0x1000, first issue_pc=0x1000.
- Redirect in the same cycle as mem_ack and an eligible issue -> no issue_valid, data dropped, next request at the redirect target.
- RESET_PC = 2^64-8, NFU=2 -> second fetch address wraps to 0x0. Assert rst mid-WAIT -> all outputs return to reset values next cycle.
